// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared types and constants for the sram_1rw_init_pipe memory model.
//   sram_init_state_e : init-sweep FSM states
//   SRAM_LFSR_POLY    : Galois LFSR taps for the garbage read-data generator
//   SRAM_LFSR_SEED    : LFSR reset seed
//   lane_width()      : bits per write-mask lane
// -----------------------------------------------------------------------------
package sram_pkg;

   typedef enum logic [0:0] {
      SRAM_INIT  = 1'b0,
      SRAM_READY = 1'b1
   } sram_init_state_e;

   localparam logic [31:0] SRAM_LFSR_POLY = 32'h8020_0003;
   localparam logic [31:0] SRAM_LFSR_SEED = 32'hACE1_ACE1;

   function automatic int unsigned lane_width(input int unsigned data_width,
                                              input int unsigned mask_width);
      return data_width / mask_width;
   endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// -----------------------------------------------------------------------------
// sram_rd_pipe
// Delay line of {valid, data} pairs, STAGES deep (STAGES >= 1).
// A stage only loads new data when the incoming valid is set, so the final
// data output keeps the last valid word while no read is in flight.
// Ports:
//   clk_i    : clock
//   rst_ni   : synchronous active-low reset, clears all stages
//   valid_i  : read result valid entering the line
//   data_i   : read data entering the line
//   valid_o  : valid after STAGES cycles
//   data_o   : data after STAGES cycles (holds last valid word)
// -----------------------------------------------------------------------------
module sram_rd_pipe #(
   parameter int unsigned STAGES     = 1,
   parameter int unsigned DATA_WIDTH = 36
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  valid_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o
);

   logic [STAGES-1:0]     valid_q;
   logic [DATA_WIDTH-1:0] data_q [STAGES];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         valid_q <= '0;
         for (int unsigned i = 0; i < STAGES; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         valid_q[0] <= valid_i;
         if (valid_i) begin
            data_q[0] <= data_i;
         end
         for (int unsigned i = 1; i < STAGES; i++) begin
            valid_q[i] <= valid_q[i-1];
            if (valid_q[i-1]) begin
               data_q[i] <= data_q[i-1];
            end
         end
      end
   end

   assign valid_o = valid_q[STAGES-1];
   assign data_o  = data_q[STAGES-1];

endmodule

// File: rtl/sram_1rw_init_pipe.sv
// -----------------------------------------------------------------------------
// sram_1rw_init_pipe
// Parametrised single-port masked-write SRAM model with a post-reset
// initialisation sweep, ready indication, out-of-range protection and a
// configurable read latency (1..4).
// Ports:
//   RW0_clk    : clock
//   RW0_rst_n  : synchronous active-low reset
//   RW0_en     : access request (accepted only while RW0_ready)
//   RW0_wmode  : 1 = write, 0 = read
//   RW0_addr   : word address (>= DEPTH: writes dropped, reads return INIT_VALUE)
//   RW0_wmask  : per-lane write enable
//   RW0_wdata  : write data
//   RW0_rdata  : read data
//   RW0_rvalid : RW0_rdata carries a read result this cycle
//   RW0_ready  : init sweep complete
// Macro SRAM_GARBAGE_RDATA_EN: when defined, RW0_rdata shows LFSR noise while
// RW0_rvalid is low; otherwise it holds the last valid read word.
// -----------------------------------------------------------------------------
module sram_1rw_init_pipe
   import sram_pkg::*;
#(
   parameter int unsigned          ADDR_WIDTH   = 13,
   parameter int unsigned          DEPTH        = 8192,
   parameter int unsigned          DATA_WIDTH   = 36,
   parameter int unsigned          MASK_WIDTH   = 6,
   parameter int unsigned          READ_LATENCY = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
   input  logic                  RW0_clk,
   input  logic                  RW0_rst_n,
   input  logic                  RW0_en,
   input  logic                  RW0_wmode,
   input  logic [ADDR_WIDTH-1:0] RW0_addr,
   input  logic [MASK_WIDTH-1:0] RW0_wmask,
   input  logic [DATA_WIDTH-1:0] RW0_wdata,
   output logic [DATA_WIDTH-1:0] RW0_rdata,
   output logic                  RW0_rvalid,
   output logic                  RW0_ready
);

   localparam int unsigned          LANE      = lane_width(DATA_WIDTH, MASK_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);

   if (DATA_WIDTH % MASK_WIDTH != 0) begin : g_chk_mask
      $error("DATA_WIDTH must be a multiple of MASK_WIDTH");
   end
   if (DEPTH < 1 || 64'(DEPTH) > (64'd1 << ADDR_WIDTH)) begin : g_chk_depth
      $error("DEPTH must be in 1..2**ADDR_WIDTH");
   end
   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_chk_lat
      $error("READ_LATENCY must be in 1..4");
   end

   sram_init_state_e      state_q;
   logic [ADDR_WIDTH-1:0] cnt_q;
   logic                  ready_q;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  acc;
   logic                  in_range;
   logic                  wr_en;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] bit_mask;
   logic [DATA_WIDTH-1:0] wr_word;

   logic                  s0_valid_d, s0_valid_q;
   logic [DATA_WIDTH-1:0] s0_data_d,  s0_data_q;

   logic                  pipe_valid;
   logic [DATA_WIDTH-1:0] pipe_data;

   always_comb begin
      acc      = RW0_en && ready_q;
      in_range = {1'b0, RW0_addr} < DEPTH_W;
      wr_en    = acc && RW0_wmode && in_range;
      rd_en    = acc && !RW0_wmode;

      bit_mask = '0;
      for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
         bit_mask[i*LANE +: LANE] = {LANE{RW0_wmask[i]}};
      end
      wr_word = (mem_q[RW0_addr] & ~bit_mask) | (RW0_wdata & bit_mask);

      // Array output register only reloads on an accepted read, so it keeps
      // the last read word for the hold-last-value behaviour downstream.
      s0_valid_d = rd_en;
      s0_data_d  = s0_data_q;
      if (rd_en) begin
         s0_data_d = in_range ? mem_q[RW0_addr] : INIT_VALUE;
      end
   end

   // Ready is registered from the state, so it rises one cycle after the
   // last sweep write.
   always_ff @(posedge RW0_clk) begin
      if (!RW0_rst_n) begin
         state_q <= SRAM_INIT;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         ready_q <= (state_q == SRAM_READY);
         case (state_q)
            SRAM_INIT: begin
               if (cnt_q == LAST_ADDR) begin
                  state_q <= SRAM_READY;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Array contents are never cleared by reset; only the sweep rewrites them.
   always_ff @(posedge RW0_clk) begin
      if (RW0_rst_n) begin
         if (state_q == SRAM_INIT) begin
            mem_q[cnt_q] <= INIT_VALUE;
         end else if (wr_en) begin
            mem_q[RW0_addr] <= wr_word;
         end
      end
   end

   always_ff @(posedge RW0_clk) begin
      if (!RW0_rst_n) begin
         s0_valid_q <= 1'b0;
         s0_data_q  <= '0;
      end else begin
         s0_valid_q <= s0_valid_d;
         s0_data_q  <= s0_data_d;
      end
   end

   if (READ_LATENCY > 1) begin : g_pipe
      sram_rd_pipe #(
         .STAGES     (READ_LATENCY - 1),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_rd_pipe (
         .clk_i   (RW0_clk),
         .rst_ni  (RW0_rst_n),
         .valid_i (s0_valid_q),
         .data_i  (s0_data_q),
         .valid_o (pipe_valid),
         .data_o  (pipe_data)
      );
   end else begin : g_no_pipe
      assign pipe_valid = s0_valid_q;
      assign pipe_data  = s0_data_q;
   end

   assign RW0_rvalid = pipe_valid;
   assign RW0_ready  = ready_q;

`ifdef SRAM_GARBAGE_RDATA_EN
   localparam int unsigned LFSR_REPS = (DATA_WIDTH + 31) / 32;

   logic [31:0]             lfsr_q, lfsr_d;
   logic [LFSR_REPS*32-1:0] lfsr_rep;

   always_comb begin
      lfsr_d = {1'b0, lfsr_q[31:1]};
      if (lfsr_q[0]) begin
         lfsr_d = lfsr_d ^ SRAM_LFSR_POLY;
      end
      lfsr_rep = {LFSR_REPS{lfsr_q}};
   end

   always_ff @(posedge RW0_clk) begin
      if (!RW0_rst_n) begin
         lfsr_q <= SRAM_LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign RW0_rdata = pipe_valid ? pipe_data : lfsr_rep[DATA_WIDTH-1:0];
`else
   assign RW0_rdata = pipe_data;
`endif

endmodule

// File: tb/tb_sram_1rw_init_pipe.sv
// -----------------------------------------------------------------------------
// tb_sram_1rw_init_pipe
// Self-checking bench for sram_1rw_init_pipe (default build) with
// ADDR_WIDTH=7, DEPTH=100, READ_LATENCY=3, INIT_VALUE=36'h5A5A5A5A5.
// A behavioural memory model predicts ready/rvalid/rdata every cycle;
// directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_sram_1rw_init_pipe;

   localparam int unsigned     AW    = 7;
   localparam int unsigned     DEPTH = 100;
   localparam int unsigned     DW    = 36;
   localparam int unsigned     MW    = 6;
   localparam int unsigned     LAT   = 3;
   localparam logic [DW-1:0]   INIT  = 36'h5A5A5A5A5;

   logic          clk    = 1'b0;
   logic          rst_n  = 1'b0;
   logic          en     = 1'b0;
   logic          wmode  = 1'b0;
   logic [AW-1:0] addr   = '0;
   logic [MW-1:0] wmask  = '0;
   logic [DW-1:0] wdata  = '0;
   logic [DW-1:0] rdata;
   logic          rvalid;
   logic          ready;

   always #5 clk = ~clk;

   sram_1rw_init_pipe #(
      .ADDR_WIDTH   (AW),
      .DEPTH        (DEPTH),
      .DATA_WIDTH   (DW),
      .MASK_WIDTH   (MW),
      .READ_LATENCY (LAT),
      .INIT_VALUE   (INIT)
   ) dut (
      .RW0_clk    (clk),
      .RW0_rst_n  (rst_n),
      .RW0_en     (en),
      .RW0_wmode  (wmode),
      .RW0_addr   (addr),
      .RW0_wmask  (wmask),
      .RW0_wdata  (wdata),
      .RW0_rdata  (rdata),
      .RW0_rvalid (rvalid),
      .RW0_ready  (ready)
   );

   int unsigned checks = 0;
   int unsigned errors = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int unsigned   due;
      logic [DW-1:0] data;
   } rd_t;

   rd_t           rd_q[$];
   logic [DW-1:0] mm [DEPTH];
   int unsigned   edge_cnt = 0;
   int unsigned   rel      = 0;   // rising edges seen since reset release
   logic [DW-1:0] last_d   = '0;

   always @(posedge clk) begin
      edge_cnt++;
      if (!rst_n) begin
         rel = 0;
         rd_q.delete();
         last_d = '0;
      end else begin
         if (rel > DEPTH && en) begin
            if (wmode) begin
               if (int'(addr) < DEPTH) begin
                  for (int i = 0; i < MW; i++) begin
                     if (wmask[i]) mm[addr][i*6 +: 6] = wdata[i*6 +: 6];
                  end
               end
            end else begin
               rd_q.push_back('{edge_cnt + LAT - 1, (int'(addr) < DEPTH) ? mm[addr] : INIT});
            end
         end
         if (rel < DEPTH) mm[AW'(rel)] = INIT;
         if (rel <= DEPTH) rel++;
      end
   end

   always @(negedge clk) begin
      logic          ev;
      logic [DW-1:0] ed;
      if (edge_cnt > 0) begin
         ev = 1'b0;
         ed = last_d;
         if (rd_q.size() > 0 && rd_q[0].due == edge_cnt) begin
            ev     = 1'b1;
            ed     = rd_q[0].data;
            last_d = ed;
            void'(rd_q.pop_front());
         end
         chk("ready",  36'(ready),  36'(rel > DEPTH));
         chk("rvalid", 36'(rvalid), 36'(ev));
         chk("rdata",  rdata,       ed);
      end
   end

   // ---------------- read-result log ----------------
   logic [DW-1:0] log_d[$];
   int unsigned   log_e[$];

   always @(negedge clk) begin
      if (rvalid === 1'b1) begin
         log_d.push_back(rdata);
         log_e.push_back(edge_cnt);
      end
   end

   // ---------------- drivers ----------------
   task automatic drive(input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [MW-1:0] m);
      @(negedge clk); #1;
      en = 1'b1; wmode = w; addr = a; wdata = d; wmask = m;
   endtask

   task automatic idle();
      @(negedge clk); #1;
      en = 1'b0; wmode = 1'b0;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
      drive(1'b1, a, d, m);
      idle();
   endtask

   task automatic wait_results(input int unsigned n0, input int unsigned n);
      int unsigned k = 0;
      while (log_d.size() < n0 + n && k < 20) begin
         @(negedge clk); #2;
         k++;
      end
      chk("result_count", 36'(log_d.size() - n0), 36'(n));
   endtask

   task automatic rd_check(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
      int unsigned n0;
      int unsigned acc;
      n0 = log_d.size();
      drive(1'b0, a, '0, '0);
      acc = edge_cnt + 1;
      idle();
      wait_results(n0, 1);
      if (log_d.size() > n0) begin
         chk(name, log_d[n0], exp);
         chk({name, "_lat"}, 36'(log_e[n0] - acc + 1), 36'(LAT));
      end
   endtask

   task automatic wait_ready(input string name, input int unsigned rel_edge);
      int unsigned k = 0;
      while (ready !== 1'b1 && k < 300) begin
         @(negedge clk); #1;
         k++;
      end
      chk(name, 36'(edge_cnt - rel_edge), 36'(DEPTH));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int unsigned rel_e;
      int unsigned n0;
      int unsigned acc0;
      int unsigned bad;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_ready",  36'(ready),  '0);
      chk("rst_rvalid", 36'(rvalid), '0);
      chk("rst_rdata",  rdata,       '0);

      // Release; requests during the sweep must be ignored.
      rst_n = 1'b1;
      rel_e = edge_cnt + 1;
      drive(1'b0, 7'd3, '0, '0);
      drive(1'b1, 7'd4, 36'h1, '1);
      idle();
      wait_ready("ready_rise", rel_e);
      chk("init_no_rvalid", 36'(log_d.size()), '0);

      // Back-to-back readback of every word plus one out-of-range address.
      n0 = log_d.size();
      for (int a = 0; a < DEPTH; a++) drive(1'b0, AW'(a), '0, '0);
      drive(1'b0, 7'd120, '0, '0);
      idle();
      wait_results(n0, DEPTH + 1);
      if (log_d.size() >= n0 + DEPTH + 1) begin
         bad = 0;
         for (int k = 0; k <= DEPTH; k++) if (log_d[n0 + k] !== INIT) bad++;
         chk("readback_all_init", 36'(bad), '0);
         chk("readback_spacing", 36'(log_e[n0 + DEPTH] - log_e[n0]), 36'(DEPTH));
      end

      // Masked writes.
      wr(7'd5, 36'hFFFFFFFFF, 6'b111111);
      wr(7'd5, 36'h000000000, 6'b000001);
      rd_check("masked_write", 7'd5, 36'hFFFFFFFC0);
      wr(7'd6, 36'h123456789, 6'b000000);
      rd_check("zero_mask", 7'd6, INIT);
      wr(7'd7, 36'hABCDEF012, 6'b101010);
      rd_check("alt_lanes", 7'd7, 36'hAA5DDA025);

      // Write followed immediately by a read of the same word.
      n0 = log_d.size();
      drive(1'b1, 7'd10, 36'h0DEADBEEF, '1);
      drive(1'b0, 7'd10, '0, '0);
      idle();
      wait_results(n0, 1);
      if (log_d.size() > n0) chk("wr_then_rd", log_d[n0], 36'h0DEADBEEF);

      // Out-of-range protection.
      wr(7'd120, 36'h123, '1);
      rd_check("oor_read", 7'd120, INIT);
      rd_check("addr99_intact", 7'd99, INIT);

      // Latency and ordering of consecutive reads.
      wr(7'd1, 36'h111, '1);
      wr(7'd2, 36'h222, '1);
      wr(7'd3, 36'h333, '1);
      n0 = log_d.size();
      drive(1'b0, 7'd1, '0, '0);
      acc0 = edge_cnt + 1;
      drive(1'b0, 7'd2, '0, '0);
      drive(1'b0, 7'd3, '0, '0);
      idle();
      wait_results(n0, 3);
      if (log_d.size() >= n0 + 3) begin
         chk("order_0", log_d[n0],     36'h111);
         chk("order_1", log_d[n0 + 1], 36'h222);
         chk("order_2", log_d[n0 + 2], 36'h333);
         chk("order_first_lat", 36'(log_e[n0] - acc0 + 1), 36'(LAT));
         chk("order_span", 36'(log_e[n0 + 2] - log_e[n0]), 36'd2);
      end

      // Idle hold of the last read word.
      repeat (4) @(negedge clk);
      #1;
      chk("idle_hold",   rdata,       36'h333);
      chk("idle_rvalid", 36'(rvalid), '0);

      // Reset with a read in flight, then reset again mid-sweep.
      wr(7'd50, 36'h777, '1);
      n0 = log_d.size();
      drive(1'b0, 7'd50, '0, '0);
      @(negedge clk); #1;
      en    = 1'b0;
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      chk("inflight_dropped", 36'(log_d.size() - n0), '0);
      chk("rst_rdata_clear",  rdata, '0);
      rst_n = 1'b1;
      repeat (7) @(negedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk); #1;
      chk("midsweep_ready", 36'(ready), '0);
      rst_n = 1'b1;
      rel_e = edge_cnt + 1;
      wait_ready("ready_rise_restart", rel_e);
      rd_check("resweep_50", 7'd50, INIT);
      rd_check("resweep_5",  7'd5,  INIT);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

endmodule
